// File: rtl/midori_stream_ctrl.sv
// Word-serial valid/ready front end for the registered Midori-128 core wrapper.
// Define MIDORI_STREAM_LSW_FIRST_EN to map word 0 to bits [31:0] (default: word 0 -> [127:96]).
module midori_stream_ctrl #(
   parameter  int unsigned CORE_LAT = 2,
   localparam int unsigned WORD_W   = 32,
   localparam int unsigned BLK_W    = 128,
   localparam int unsigned TCNT_W   = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_key,
   input  logic              in_enc,
   output logic              core_enc,
   output logic [BLK_W-1:0]  core_K,
   output logic [BLK_W-1:0]  core_P,
   input  logic [BLK_W-1:0]  core_C,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [BLK_W-1:0]  res_data,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_K,
      S_LOAD_P,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t             state, state_n;
   logic [1:0]         wcnt, wcnt_n;
   logic [TCNT_W-1:0]  tcnt, tcnt_n;
   logic [BLK_W-1:0]   key_buf, key_buf_n;
   logic [BLK_W-1:0]   txt_buf, txt_buf_n;
   logic               job_enc, job_enc_n;
   logic               core_enc_n;
   logic [BLK_W-1:0]   core_k_n, core_p_n;
   logic               res_valid_n;
   logic [BLK_W-1:0]   res_data_n;
   logic               in_ready_n, busy_n;
   logic               xfer;

   // Insert one stream word into its lane of a 128-bit block.
   function automatic logic [BLK_W-1:0] put_lane(input logic [BLK_W-1:0]  blk,
                                                 input logic [1:0]        idx,
                                                 input logic [WORD_W-1:0] word);
      logic [BLK_W-1:0] r;
      logic [1:0]       lane;
      r = blk;
`ifdef MIDORI_STREAM_LSW_FIRST_EN
      lane = idx;
`else
      lane = 2'd3 - idx;
`endif
      r[int'(lane)*WORD_W +: WORD_W] = word;
      return r;
   endfunction

   assign xfer = in_valid && in_ready;

   // State register and all datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         wcnt      <= 2'd0;
         tcnt      <= '0;
         key_buf   <= '0;
         txt_buf   <= '0;
         job_enc   <= 1'b0;
         core_enc  <= 1'b0;
         core_K    <= '0;
         core_P    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         wcnt      <= wcnt_n;
         tcnt      <= tcnt_n;
         key_buf   <= key_buf_n;
         txt_buf   <= txt_buf_n;
         job_enc   <= job_enc_n;
         core_enc  <= core_enc_n;
         core_K    <= core_k_n;
         core_P    <= core_p_n;
         res_valid <= res_valid_n;
         res_data  <= res_data_n;
         in_ready  <= in_ready_n;
         busy      <= busy_n;
      end
   end

   // Next-state and next-register logic.
   always_comb begin
      state_n     = state;
      wcnt_n      = wcnt;
      tcnt_n      = tcnt;
      key_buf_n   = key_buf;
      txt_buf_n   = txt_buf;
      job_enc_n   = job_enc;
      core_enc_n  = core_enc;
      core_k_n    = core_K;
      core_p_n    = core_P;
      res_valid_n = res_valid;
      res_data_n  = res_data;

      unique case (state)
         S_IDLE: begin
            if (xfer) begin
               job_enc_n = in_enc;
               wcnt_n    = 2'd1;
               if (in_key) begin
                  key_buf_n = put_lane(key_buf, 2'd0, in_data);
                  state_n   = S_LOAD_K;
               end else begin
                  txt_buf_n = put_lane(txt_buf, 2'd0, in_data);
                  state_n   = S_LOAD_P;
               end
            end
         end
         S_LOAD_K: begin
            if (xfer) begin
               key_buf_n = put_lane(key_buf, wcnt, in_data);
               if (wcnt == 2'd3) begin
                  wcnt_n  = 2'd0;
                  state_n = S_LOAD_P;
               end else begin
                  wcnt_n = wcnt + 2'd1;
               end
            end
         end
         S_LOAD_P: begin
            if (xfer) begin
               txt_buf_n = put_lane(txt_buf, wcnt, in_data);
               if (wcnt == 2'd3) begin
                  // Commit: operands to the wrapper change only here.
                  core_p_n   = txt_buf_n;
                  core_k_n   = key_buf;
                  core_enc_n = job_enc;
                  tcnt_n     = '0;
                  wcnt_n     = 2'd0;
                  state_n    = S_WAIT;
               end else begin
                  wcnt_n = wcnt + 2'd1;
               end
            end
         end
         S_WAIT: begin
            if (tcnt == TCNT_W'(CORE_LAT)) begin
               res_data_n  = core_C;
               res_valid_n = 1'b1;
               state_n     = S_HOLD;
            end else begin
               tcnt_n = tcnt + TCNT_W'(1);
            end
         end
         S_HOLD: begin
            if (res_ready) begin
               res_valid_n = 1'b0;
               state_n     = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      in_ready_n = (state_n == S_IDLE) || (state_n == S_LOAD_K) || (state_n == S_LOAD_P);
      busy_n     = (state_n != S_IDLE);
   end

endmodule

// File: tb/tb_midori_stream_ctrl.sv
// Directed self-checking bench for midori_stream_ctrl with a two-stage stand-in wrapper.
// Honours MIDORI_STREAM_LSW_FIRST_EN for the expected word-to-lane mapping.
module tb_midori_stream_ctrl;

   localparam logic [127:0] CST = 128'hc055cbb95996d14902b60574d5e728d6;
   localparam logic [127:0] KS  = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam logic [127:0] PT  = 128'h3243f6a8_885a308d_313198a2_e0370734;
   localparam logic [127:0] RS  = 128'h01234567_89abcdef_fedcba98_76543210;
`ifdef MIDORI_STREAM_LSW_FIRST_EN
   localparam logic [127:0] RS_P = 128'h76543210_fedcba98_89abcdef_01234567;
`else
   localparam logic [127:0] RS_P = 128'h01234567_89abcdef_fedcba98_76543210;
`endif

   logic         clk, rst;
   logic         in_valid, in_ready, in_key, in_enc;
   logic [31:0]  in_data;
   logic         core_enc;
   logic [127:0] core_K, core_P, core_C;
   logic         res_valid, res_ready, busy;
   logic [127:0] res_data;

   int compares = 0;
   int mism     = 0;
   int cyc      = 0;

   logic         m_enc;
   logic [127:0] m_k, m_p;

   midori_stream_ctrl dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_key(in_key), .in_enc(in_enc),
      .core_enc(core_enc), .core_K(core_K), .core_P(core_P), .core_C(core_C),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Invertible stand-in cipher; not Midori, but keyed, direction-aware and exact.
   function automatic logic [127:0] core_ref(input logic e, input logic [127:0] k,
                                             input logic [127:0] x);
      logic [127:0] t;
      if (e) begin
         t = x ^ k;
         return {t[114:0], t[127:115]} ^ CST;
      end else begin
         t = x ^ CST;
         return {t[12:0], t[127:13]} ^ k;
      end
   endfunction

   // Wrapper model: inputs registered on one edge, C on the next.
   always @(posedge clk) begin
      m_enc  <= core_enc;
      m_k    <= core_K;
      m_p    <= core_P;
      core_C <= core_ref(m_enc, m_k, m_p);
   end

   // Block assembled from a word sequence given with word 0 in the top 32 bits.
   function automatic logic [127:0] blk(input logic [127:0] s);
`ifdef MIDORI_STREAM_LSW_FIRST_EN
      return {s[31:0], s[63:32], s[95:64], s[127:96]};
`else
      return s;
`endif
   endfunction

   task automatic put_word(input logic [31:0] d, input logic k, input logic e);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         $display("FAIL put_word: in_ready=%b required 1 within 50 cycles", in_ready);
         $fatal(1, "input stream stalled");
      end
      in_valid = 1'b1; in_data = d; in_key = k; in_enc = e;
      @(negedge clk);
      in_valid = 1'b0; in_data = '0; in_key = 1'b0; in_enc = 1'b0;
   endtask

   // Non-first words carry inverted enc and kflag-driven in_key; both must be ignored.
   task automatic send_frame(input logic wk, input logic e, input logic [127:0] kseq,
                             input logic [127:0] tseq, input logic [3:0] kflag,
                             input int maxgap);
      if (wk) begin
         for (int i = 0; i < 4; i++) begin
            put_word(kseq[127-32*i -: 32], (i == 0), (i == 0) ? e : ~e);
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
         end
      end
      for (int i = 0; i < 4; i++) begin
         put_word(tseq[127-32*i -: 32], (!wk && i == 0) ? 1'b0 : kflag[i],
                  (!wk && i == 0) ? e : ~e);
         if (i < 3) repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (res_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic hold_result(input int n, output logic stable, output logic rdy_seen);
      logic [127:0] first;
      first = res_data; stable = 1'b1; rdy_seen = 1'b0;
      res_ready = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (res_data !== first || res_valid !== 1'b1) stable = 1'b0;
         if (in_ready !== 1'b0) rdy_seen = 1'b1;
      end
   endtask

   task automatic release_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b1; in_key = 1'b1; in_enc = 1'b1; in_data = '1; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      compares++; if (in_ready !== 1'b0) begin mism++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      compares++; if (busy !== 1'b0) begin mism++; $display("FAIL reset_busy: got %b want 0", busy); end
      compares++; if (res_valid !== 1'b0) begin mism++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
      compares++; if (core_enc !== 1'b0) begin mism++; $display("FAIL reset_core_enc: got %b want 0", core_enc); end
      compares++; if ({core_K, core_P, res_data} !== '0) begin mism++; $display("FAIL reset_blocks: K=%h P=%h R=%h want 0", core_K, core_P, res_data); end
      in_valid = 1'b0; in_key = 1'b0; in_enc = 1'b0; in_data = '0;
      rst = 1'b1;
      @(negedge clk);
      compares++; if (in_ready !== 1'b1) begin mism++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
      compares++; if (busy !== 1'b0) begin mism++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_key_frame();
      int lat;
      send_frame(1'b1, 1'b1, '0, '0, 4'b0000, 0);
      compares++; if (core_enc !== 1'b1) begin mism++; $display("FAIL kf_enc: got %b want 1", core_enc); end
      compares++; if (core_K !== '0 || core_P !== '0) begin mism++; $display("FAIL kf_operands: K=%h P=%h want 0", core_K, core_P); end
      compares++; if (in_ready !== 1'b0 || busy !== 1'b1) begin mism++; $display("FAIL kf_wait_flags: in_ready=%b busy=%b want 0/1", in_ready, busy); end
      wait_result(lat);
      compares++; if (lat != 3) begin mism++; $display("FAIL kf_latency: got %0d edges want 3", lat); end
      compares++; if (res_data !== CST) begin mism++; $display("FAIL kf_result: got %h want %h", res_data, CST); end
      release_result();
   endtask

   task automatic test_key_reuse();
      int lat;
      send_frame(1'b0, 1'b1, '0, RS, 4'b0000, 0);
      compares++; if (core_K !== '0) begin mism++; $display("FAIL reuse_key: got %h want 0", core_K); end
      compares++; if (core_P !== RS_P) begin mism++; $display("FAIL reuse_text: got %h want %h", core_P, RS_P); end
      wait_result(lat);
      compares++; if (res_data !== core_ref(1'b1, '0, RS_P)) begin mism++; $display("FAIL reuse_result: got %h want %h", res_data, core_ref(1'b1, '0, RS_P)); end
      release_result();
   endtask

   task automatic test_round_trip();
      int lat;
      logic [127:0] ct;
      send_frame(1'b1, 1'b1, KS, PT, 4'b0000, 0);
      compares++; if (core_K !== blk(KS)) begin mism++; $display("FAIL rt_key: got %h want %h", core_K, blk(KS)); end
      compares++; if (core_P !== blk(PT)) begin mism++; $display("FAIL rt_text: got %h want %h", core_P, blk(PT)); end
      wait_result(lat);
      ct = res_data;
      compares++; if (ct !== core_ref(1'b1, blk(KS), blk(PT))) begin mism++; $display("FAIL rt_cipher: got %h want %h", ct, core_ref(1'b1, blk(KS), blk(PT))); end
      release_result();
      send_frame(1'b0, 1'b0, '0, blk(ct), 4'b0000, 0);
      compares++; if (core_enc !== 1'b0 || core_P !== ct) begin mism++; $display("FAIL rt_dec_operands: enc=%b P=%h want 0/%h", core_enc, core_P, ct); end
      wait_result(lat);
      compares++; if (res_data !== blk(PT)) begin mism++; $display("FAIL rt_plain: got %h want %h", res_data, blk(PT)); end
      release_result();
   endtask

   task automatic test_stalls();
      int lat, extra;
      logic stable, rdy_seen;
      logic [127:0] ts, exp;
      ts  = 128'hdeadbeef_0badf00d_13579bdf_2468ace0;
      exp = core_ref(1'b1, blk(KS), blk(ts));
      send_frame(1'b0, 1'b1, '0, ts, 4'b0000, 3);
      compares++; if (core_P !== blk(ts) || core_K !== blk(KS)) begin mism++; $display("FAIL stall_operands: K=%h P=%h want %h/%h", core_K, core_P, blk(KS), blk(ts)); end
      wait_result(lat);
      compares++; if (lat != 3) begin mism++; $display("FAIL stall_latency: got %0d edges want 3", lat); end
      hold_result(10, stable, rdy_seen);
      compares++; if (stable !== 1'b1) begin mism++; $display("FAIL stall_hold_stable: got %b want 1", stable); end
      compares++; if (rdy_seen !== 1'b0) begin mism++; $display("FAIL stall_hold_in_ready: raised=%b want 0", rdy_seen); end
      compares++; if (res_data !== exp) begin mism++; $display("FAIL stall_result: got %h want %h", res_data, exp); end
      release_result();
      extra = 0;
      repeat (6) begin
         if (res_valid !== 1'b0) extra++;
         @(negedge clk);
      end
      compares++; if (extra != 0) begin mism++; $display("FAIL stall_single_result: extra valid cycles %0d want 0", extra); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [127:0] ns;
      ns = 128'h11111111_22222222_33333333_44444444;
      put_word(32'hAAAA5555, 1'b0, 1'b1);
      put_word(32'h5555AAAA, 1'b0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      compares++; if (busy !== 1'b0 || in_ready !== 1'b0 || core_K !== '0) begin mism++; $display("FAIL midreset_state: busy=%b in_ready=%b K=%h want 0/0/0", busy, in_ready, core_K); end
      rst = 1'b1;
      @(negedge clk);
      send_frame(1'b0, 1'b1, '0, ns, 4'b0000, 0);
      compares++; if (core_K !== '0 || core_P !== blk(ns)) begin mism++; $display("FAIL midreset_operands: K=%h P=%h want 0/%h", core_K, core_P, blk(ns)); end
      wait_result(lat);
      compares++; if (lat != 3 || res_data !== core_ref(1'b1, '0, blk(ns))) begin mism++; $display("FAIL midreset_result: lat=%0d got %h want 3/%h", lat, res_data, core_ref(1'b1, '0, blk(ns))); end
      release_result();
   endtask

   task automatic test_key_ignored();
      int lat;
      logic [127:0] is;
      is = 128'hcafef00d_feedface_01020304_a5a5a5a5;
      send_frame(1'b0, 1'b0, '0, is, 4'b1110, 0);
      compares++; if (in_ready !== 1'b0 || busy !== 1'b1) begin mism++; $display("FAIL kign_committed: in_ready=%b busy=%b want 0/1", in_ready, busy); end
      compares++; if (core_P !== blk(is) || core_enc !== 1'b0 || core_K !== '0) begin mism++; $display("FAIL kign_operands: enc=%b K=%h P=%h want 0/0/%h", core_enc, core_K, core_P, blk(is)); end
      wait_result(lat);
      compares++; if (res_data !== core_ref(1'b0, '0, blk(is))) begin mism++; $display("FAIL kign_result: got %h want %h", res_data, core_ref(1'b0, '0, blk(is))); end
      release_result();
   endtask

   task automatic test_back_to_back();
      int lat, c0, c1;
      logic [127:0] k2, t2;
      k2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      t2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
      res_ready = 1'b1;
      c0 = cyc;
      send_frame(1'b1, 1'b1, k2, t2, 4'b0000, 0);
      c1 = cyc;
      compares++; if (c1 - c0 != 8) begin mism++; $display("FAIL b2b_accept_cycles: got %0d want 8", c1 - c0); end
      wait_result(lat);
      compares++; if (lat != 3) begin mism++; $display("FAIL b2b_latency: got %0d edges want 3", lat); end
      compares++; if (res_data !== core_ref(1'b1, blk(k2), blk(t2))) begin mism++; $display("FAIL b2b_result: got %h want %h", res_data, core_ref(1'b1, blk(k2), blk(t2))); end
      @(negedge clk);
      compares++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin mism++; $display("FAIL b2b_min_hold: res_valid=%b in_ready=%b busy=%b want 0/1/0", res_valid, in_ready, busy); end
      res_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_key_frame();
      test_key_reuse();
      test_round_trip();
      test_stalls();
      test_reset_mid();
      test_key_ignored();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
      $finish;
   end

endmodule

// File: doc/midori_stream_ctrl.md
# midori_stream_ctrl

Word-serial front end for the registered Midori-128 core wrapper. It assembles 128-bit key and plaintext/ciphertext blocks from a 32-bit valid/ready stream and presents them as stable, registered operands (enc, K, P) to the core wrapper. It then waits out the wrapper's fixed register latency, captures the 128-bit result, and offers it on a valid/ready result port. It sits directly upstream of the wrapper and also consumes the wrapper's C output.

## Interface
- CORE_LAT, 2, clock edges from a change on core_* until the wrapper's C output reflects it. The wrapper registers its inputs on one edge and C on the next.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts a word; a transfer occurs when in_valid & in_ready at a rising edge
- in_data  in  32  key or text word
- in_key  in  1  sampled only with the first word of a frame: 1 = frame carries a new key, 0 = reuse the stored key
- in_enc  in  1  sampled only with the first word of a frame: 1 = encrypt, 0 = decrypt
- core_enc  out  1  to wrapper enc
- core_K  out  128  to wrapper K
- core_P  out  128  to wrapper P
- core_C  in  128  from wrapper C
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready; handshake completes when res_valid & res_ready
- res_data  out  128  captured result block
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD_K, LOAD_P, WAIT, HOLD. A 2-bit word counter (wcnt) and a wait timer (tcnt) support the states.
- Frame format: 4 key words (only if in_key=1 on the first word), then 4 text words.
- IDLE: in_ready=1. On a transfer, latch in_enc into job_enc.
  - If in_key=1: store the word as key word 0, wcnt=1, go to LOAD_K.
  - Otherwise: store the word as text word 0, wcnt=1, go to LOAD_P.
- LOAD_K: in_ready=1. Each transfer stores key word wcnt and increments wcnt. After the transfer of word 3, set wcnt=0 and go to LOAD_P.
- LOAD_P: in_ready=1. Each transfer stores text word wcnt. The transfer of word 3 is the commit, and in that same edge:
  - core_P ← assembled text block
  - core_K ← key buffer
  - core_enc ← job_enc
  - tcnt=0
  - go to WAIT
- core_K, core_P and core_enc change only at commit. They stay stable through WAIT and HOLD.
- The key buffer persists across frames until the next key frame. After reset it is all-zero, so a text-only first frame uses key 0.
- in_key and in_enc on non-first words are ignored.
- WAIT: in_ready=0. tcnt increments each edge. On the edge where tcnt==CORE_LAT: res_data ← core_C, res_valid ← 1, go to HOLD.
- HOLD: in_ready=0. res_valid and res_data are held until res_ready=1. On that handshake edge: res_valid ← 0, go to IDLE.
- Word order (default): word 0 maps to bits [127:96], word 3 to bits [31:0]. This applies to both key and text.

## Timing
- Reset values: in_ready=0 during reset, 1 after the first edge in IDLE. All other outputs reset to 0: core_enc, core_K, core_P, res_valid, res_data, busy. Key buffer, text buffer, wcnt and tcnt also reset to 0.
- Reset mid-frame or mid-WAIT returns to IDLE immediately. Partial words are discarded; no result is produced.
- Throughput with back-to-back in_valid: 4 or 8 accept cycles, then CORE_LAT+1 WAIT cycles, then HOLD for at least 1 cycle.
- Latency: res_valid rises CORE_LAT+1 edges after the commit edge (3 edges at the default).
- in_valid may drop between words. The counter holds and nothing is lost.
- res_ready high before res_valid has no effect. If res_ready is held high, the minimum HOLD is 1 cycle, then the block returns to IDLE.
- IDLE accepts the next frame's first word only on the edge after the result handshake. There is no overlap of result and input.

## Configuration
- MIDORI_STREAM_LSW_FIRST_EN:
  - Defined: word 0 maps to bits [31:0] and word 3 to bits [127:96], for key and text.
  - Undefined: the MS-word-first mapping described above.
  - No other behaviour changes.

## Test plan
- Key frame, encrypt: in_key=1, in_enc=1, key words 0x00000000 ×4, text words 0x00000000 ×4.
  - Expect core_K=0, core_P=0, core_enc=1 at commit.
  - Expect res_valid 3 edges later, with res_data equal to the core's C for the all-zero vector.
- Key reuse: follow the above with a text-only frame (in_key=0), words 0x01234567, 0x89ABCDEF, 0xFEDCBA98, 0x76543210.
  - Expect core_K unchanged.
  - Expect core_P=0x0123456789ABCDEFFEDCBA9876543210 (LSW-first build: 0x76543210FEDCBA9889ABCDEF01234567).
- Round trip: encrypt frame, then decrypt frame (in_enc=0) using the captured ciphertext → res_data equals the original plaintext.
- Stalls: random in_valid gaps, and res_ready held low 10 cycles.
  - Expect res_data stable and in_ready=0 throughout HOLD.
  - Expect exactly one result per frame.
- Reset after 2 of 4 text words, then a full text-only frame → result uses the zero key (key buffer cleared) and only the new words.
- in_key=1 asserted on a non-first text word → ignored; no extra key words are consumed.
